// File: rtl/backtrack_ctrl.sv
// -----------------------------------------------------------------------------
// backtrack_ctrl
//
// Conflict-resolution sequencer for the DPLL solver. After a conflict the
// top-level control pulses start. This block then owns the trace stack, the
// var state table and the imply queue until it finishes. It flushes the imply
// queue and pops the trace down to the most recent decision, unassigning each
// implied variable. It flips that decision's value in the var state table and
// re-pushes it as an implied entry. If the trace empties before a decision is
// found, the formula is unsatisfiable.
//
// Ports:
//   clock, reset      : system clock; synchronous active-high reset
//   start             : begin a backtrack (only honoured in IDLE)
//   empty_trace       : trace stack is empty
//   var/val/type_out_trace : top-of-trace entry (type 1 = decision)
//   pop_trace         : pop the trace top at this edge
//   push_trace, var/val/type_in_trace : push an entry at this edge
//   write_vs, var_in_vs, val_in_vs, unassign_in_vs : var state table write
//   clear_imply       : one-cycle flush of the imply queue
//   busy              : backtrack in progress (registered)
//   done              : one-cycle completion pulse (registered)
//   unsat             : sticky, no decision left to flip (registered)
//   flip_var          : decision variable that was flipped, valid with done
//   unwind_cnt        : entries popped, flipped decision included (saturating)
// -----------------------------------------------------------------------------
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 8
`endif

module backtrack_ctrl #(
    parameter int VAR_BITS = `MAX_VARS_BITS,
    parameter int CNT_BITS = `MAX_VARS_BITS + 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                empty_trace,
    input  logic [VAR_BITS-1:0] var_out_trace,
    input  logic                val_out_trace,
    input  logic                type_out_trace,
    output logic                pop_trace,
    output logic                push_trace,
    output logic [VAR_BITS-1:0] var_in_trace,
    output logic                val_in_trace,
    output logic                type_in_trace,
    output logic                write_vs,
    output logic [VAR_BITS-1:0] var_in_vs,
    output logic                val_in_vs,
    output logic                unassign_in_vs,
    output logic                clear_imply,
    output logic                busy,
    output logic                done,
    output logic                unsat,
    output logic [VAR_BITS-1:0] flip_var,
    output logic [CNT_BITS-1:0] unwind_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_UNWIND,
        S_PUSH,
        S_DONE,
        S_UNSAT
    } state_t;

    state_t              state;
    logic [VAR_BITS-1:0] lat_var;   // decision variable being flipped
    logic                lat_val;   // its new (inverted) value

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            lat_var    <= '0;
            lat_val    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            unsat      <= 1'b0;
            flip_var   <= '0;
            unwind_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_FLUSH;
                        busy       <= 1'b1;
                        unwind_cnt <= '0;
                    end
                end
                S_FLUSH: state <= S_UNWIND;
                S_UNWIND: begin
                    if (empty_trace) begin
                        // Nothing left to flip: park in UNSAT until reset.
                        state <= S_UNSAT;
                        busy  <= 1'b0;
                        unsat <= 1'b1;
                    end else begin
                        if (unwind_cnt != '1)
                            unwind_cnt <= unwind_cnt + CNT_BITS'(1);
                        if (type_out_trace) begin
                            lat_var <= var_out_trace;
                            lat_val <= ~val_out_trace;
                            state   <= S_PUSH;
                        end
                    end
                end
                S_PUSH: begin
                    state    <= S_DONE;
                    done     <= 1'b1;
                    flip_var <= lat_var;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                S_UNSAT: ;
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Strobes are decoded from the state and the trace head. They are gated by
    // reset so an abort mid-unwind issues no further pops or writes.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        pop_trace      = 1'b0;
        push_trace     = 1'b0;
        var_in_trace   = '0;
        val_in_trace   = 1'b0;
        type_in_trace  = 1'b0;
        write_vs       = 1'b0;
        var_in_vs      = '0;
        val_in_vs      = 1'b0;
        unassign_in_vs = 1'b0;
        clear_imply    = 1'b0;
        if (!reset) begin
            case (state)
                S_FLUSH: clear_imply = 1'b1;
                S_UNWIND: begin
                    if (!empty_trace) begin
                        pop_trace = 1'b1;
                        write_vs  = 1'b1;
                        var_in_vs = var_out_trace;
                        if (type_out_trace)
                            val_in_vs = ~val_out_trace;
                        else
                            unassign_in_vs = 1'b1;
                    end
                end
                S_PUSH: begin
                    push_trace   = 1'b1;
                    var_in_trace = lat_var;
                    val_in_trace = lat_val;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/backtrack_ctrl.md
Name: backtrack_ctrl

Overview:
- Conflict-resolution sequencer for the DPLL solver.
- On a conflict reported by the BCP core, the top-level control pulses `start`; this block then takes ownership of the trace stack, the var state table and the imply queue.
- It unwinds the trace to the most recent unflipped decision, unassigning each popped variable, then reasserts that decision's variable with the opposite value as an implied entry.
- It reports completion (`done`) or proves the formula unsatisfiable (`unsat`, when the trace empties with no decision left).

Parameters:
- VAR_BITS, default `MAX_VARS_BITS: width of a variable index.
- CNT_BITS, default `MAX_VARS_BITS+1: width of the unwind counter.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high; returns the block to IDLE.
- start  in  1  begin backtrack; sampled only in IDLE.
- empty_trace  in  1  trace stack empty.
- var_out_trace  in  VAR_BITS  top-of-trace variable, combinational, valid when !empty_trace.
- val_out_trace  in  1  top-of-trace value.
- type_out_trace  in  1  top-of-trace type: 1=decision, 0=implied.
- pop_trace  out  1  pop trace top at this clock edge.
- push_trace  out  1  push {var_in_trace, val_in_trace, type_in_trace} at this edge.
- var_in_trace  out  VAR_BITS  push variable.
- val_in_trace  out  1  push value.
- type_in_trace  out  1  push type; always 0 (implied).
- write_vs  out  1  var state write strobe.
- var_in_vs  out  VAR_BITS  var state index.
- val_in_vs  out  1  var state value.
- unassign_in_vs  out  1  1=mark variable unassigned, 0=assign val_in_vs.
- clear_imply  out  1  flush the imply queue (one cycle).
- busy  out  1  high in every state except IDLE and UNSAT.
- done  out  1  one-cycle pulse: backtrack complete.
- unsat  out  1  sticky; set when no decision is left to flip.
- flip_var  out  VAR_BITS  decision variable flipped; valid with done.
- unwind_cnt  out  CNT_BITS  entries popped in the last backtrack, flipped decision included; valid with done.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - All outputs are 0; unsat, flip_var, unwind_cnt and the internal latches are cleared.
  - Reset wins over start. Reset mid-unwind aborts immediately; no further strobes are issued.
- Output timing:
  - Strobes (pop_trace, push_trace, write_vs, clear_imply) and their data buses are a combinational decode of state and the trace head.
  - busy, done, unsat, flip_var and unwind_cnt are registered.
- States:
  - IDLE:
    - start=1 goes to FLUSH and clears unwind_cnt; start=0 stays.
  - FLUSH (1 cycle):
    - clear_imply=1, then go to UNWIND.
  - UNWIND, one trace entry per cycle:
    - empty_trace=1: no strobes; go to UNSAT.
    - type_out_trace=0:
      - pop_trace=1, write_vs=1, var_in_vs=var_out_trace, unassign_in_vs=1.
      - unwind_cnt++; stay in UNWIND.
    - type_out_trace=1:
      - pop_trace=1, write_vs=1, var_in_vs=var_out_trace, val_in_vs=~val_out_trace, unassign_in_vs=0.
      - Latch var_out_trace and ~val_out_trace; unwind_cnt++; go to PUSH.
  - PUSH (1 cycle):
    - push_trace=1, var_in_trace=latched var, val_in_trace=latched ~val, type_in_trace=0.
    - Go to DONE.
  - DONE (1 cycle):
    - done=1, flip_var=latched var; go to IDLE.
  - UNSAT:
    - unsat=1, busy=0; all strobes 0.
    - start is ignored; only reset exits.
- Timing:
  - Latency from the start edge with k implied entries above the decision: FLUSH at cycle 1, UNWIND cycles 2..k+2, PUSH at k+3, done=1 at k+4.
  - UNSAT with k implied entries and no decision: unsat rises at cycle k+3.
- Boundary conditions:
  - start while busy or in UNSAT is ignored; it is not queued.
  - A flipped decision is re-pushed as implied, so a later conflict unwinds past it to the next-older decision.
  - pop_trace and push_trace are never asserted in the same cycle.
  - unwind_cnt saturates at its all-ones value.
  - The trace stack must not change except via this block's strobes while busy=1.

Test Plan:
- Reset then idle: reset=1 for 1 cycle, start=0 for 5 cycles -> all outputs 0, busy=0, no strobes.
- Trace (bottom→top) {v3=1 dec, v5=0 imp, v7=1 imp}, pulse start:
  - clear_imply at cycle 1.
  - Unassign v7 at cycle 2, v5 at cycle 3.
  - Cycle 4: write v3=0 with unassign=0.
  - Cycle 5: push {v3,0,type 0}.
  - Cycle 6: done=1, flip_var=3, unwind_cnt=3.
- Trace {v2=1 dec} only -> done at cycle 4, flip_var=2, unwind_cnt=1; the trace then holds {v2,0,imp}.
- Trace {v1=0 imp, v4=1 imp}, no decision -> two unassigns, then unsat=1 at cycle 5; later start pulses produce no strobes.
- start pulsed again at cycle 3 of an active backtrack -> ignored; a single done pulse at the normal cycle.
- Reset asserted during UNWIND after one pop -> next cycle IDLE, no push, done=0, unwind_cnt=0.
